// File: rtl/joy_capture.sv
// Joystick capture unit: synchronised inputs, press edges, sticky latches, saturating
// press counters and a vblank-locked snapshot per channel, read through an 8-bit port.
module joy_capture #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int SNAP_VBL = 1,
    parameter int ADDR_W   = $clog2(CHANNELS) + 3
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] joy_in,
    input  logic                      vblank,
    input  logic                      rd,
    input  logic [ADDR_W-1:0]         addr,
    output logic [7:0]                rd_data,
    output logic                      rd_valid,
    output logic                      any_press
);
    localparam int N     = CHANNELS * WIDTH;
    localparam int IDX_W = ADDR_W + 1;

    logic [N-1:0]          sync1_q, sync1_d;
    logic [N-1:0]          cur_q, cur_d;
    logic [N-1:0]          prev_q, prev_d;
    logic [N-1:0]          snap_q, snap_d;
    logic [N-1:0]          sticky_q, sticky_d;
    logic [CHANNELS*8-1:0] cnt_q, cnt_d;
    logic                  vbl_q, vbl_d;
    logic                  any_press_q, any_press_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic [N-1:0]          press;
    logic [CHANNELS-1:0]   chan_press;
    logic                  vbl_rise;
    logic [N-1:0]          sticky_clr;
    logic [CHANNELS-1:0]   cnt_clr;
    logic [IDX_W-1:0]      chan_idx;
    logic [2:0]            reg_sel;
    logic                  chan_ok;
    logic [7:0]            rd_value;
    logic [15:0]           snap16;
    logic [15:0]           sticky16;
    logic [15:0]           clr16;

    // Input path: two-flop synchroniser into cur, one more stage for edge detection.
    always_comb begin
        sync1_d     = joy_in;
        cur_d       = sync1_q;
        prev_d      = cur_q;
        press       = cur_q & ~prev_q;
        any_press_d = |press;
        vbl_d       = vblank;
        vbl_rise    = vblank & ~vbl_q;
        chan_press  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            chan_press[c] = |press[c*WIDTH +: WIDTH];
        end
        if (SNAP_VBL != 0) begin
            snap_d = vbl_rise ? cur_q : snap_q;
        end else begin
            snap_d = cur_q;
        end
    end

    // Read port: rd is a one-cycle strobe with no back-pressure; every strobe is answered
    // by rd_valid exactly one cycle later, with rd_data holding until the next strobe.
    always_comb begin
        chan_idx   = {1'b0, addr} >> 3;
        reg_sel    = addr[2:0];
        chan_ok    = chan_idx < IDX_W'(CHANNELS);
        rd_value   = 8'h00;
        sticky_clr = '0;
        cnt_clr    = '0;
        snap16     = 16'h0000;
        sticky16   = 16'h0000;
        clr16      = 16'h0000;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_ok && chan_idx == IDX_W'(c)) begin
                snap16   = 16'(snap_q[c*WIDTH +: WIDTH]);
                sticky16 = 16'(sticky_q[c*WIDTH +: WIDTH]);
                case (reg_sel)
                    3'd0:    rd_value = snap16[7:0];
                    3'd1:    rd_value = snap16[15:8];
                    3'd2:    rd_value = sticky16[7:0];
                    3'd3:    rd_value = sticky16[15:8];
                    3'd4:    rd_value = cnt_q[c*8 +: 8];
                    3'd5:    rd_value = {7'd0, cur_q[c*WIDTH +: WIDTH] != snap_q[c*WIDTH +: WIDTH]};
                    default: rd_value = 8'h00;
                endcase
                if (rd && reg_sel == 3'd2) begin
                    clr16 = 16'h00FF;
                end else if (rd && reg_sel == 3'd3) begin
                    clr16 = 16'hFF00;
                end
                sticky_clr[c*WIDTH +: WIDTH] = clr16[WIDTH-1:0];
                cnt_clr[c] = rd && (reg_sel == 3'd4);
            end
        end
    end

    // Clear is applied before the new press is merged, so a same-cycle press survives.
    always_comb begin
        sticky_d = (sticky_q & ~sticky_clr) | press;
        cnt_d    = cnt_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cnt_clr[c]) begin
                cnt_d[c*8 +: 8] = chan_press[c] ? 8'd1 : 8'd0;
            end else if (chan_press[c] && cnt_q[c*8 +: 8] != 8'hFF) begin
                cnt_d[c*8 +: 8] = cnt_q[c*8 +: 8] + 8'd1;
            end
        end
        rd_valid_d = rd;
        rd_data_d  = rd ? rd_value : rd_data_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            cur_q       <= '0;
            prev_q      <= '0;
            snap_q      <= '0;
            sticky_q    <= '0;
            cnt_q       <= '0;
            vbl_q       <= 1'b0;
            any_press_q <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            cur_q       <= cur_d;
            prev_q      <= prev_d;
            snap_q      <= snap_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            vbl_q       <= vbl_d;
            any_press_q <= any_press_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign any_press = any_press_q;

endmodule
